branch_ctrl: RTL and testbench

- Sequences branch resolution for the core's branch comparator path.
- Accepts one conditional branch at a time over a valid/ready handshake and evaluates the func3 condition on registered operands.
- Computes the taken target and drives the fetch redirect and pipeline flush.
- Sits between decode/execute and the fetch PC mux.

---
 rtl/branch_ctrl_if.sv | 30 +++
 rtl/branch_ctrl.sv | 153 +++++++++++++++
 tb/tb_branch_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_if.sv
// Branch request / resolution bus between decode-execute, branch_ctrl and the fetch PC mux.
// master: requester side (decode/execute and fetch); slave: branch_ctrl.
interface branch_ctrl_if #(
   parameter int VAR_WIDTH = 32
);
   logic                 br_valid;
   logic                 br_ready;
   logic [2:0]           func3;
   logic [VAR_WIDTH-1:0] rs1;
   logic [VAR_WIDTH-1:0] rs2;
   logic [VAR_WIDTH-1:0] pc;
   logic [VAR_WIDTH-1:0] imm;
   logic                 stall;
   logic                 resolve_valid;
   logic                 taken;
   logic                 illegal;
   logic                 redirect_valid;
   logic [VAR_WIDTH-1:0] redirect_pc;
   logic                 flush;

   modport master (
      output br_valid, func3, rs1, rs2, pc, imm, stall,
      input  br_ready, resolve_valid, taken, illegal, redirect_valid, redirect_pc, flush
   );

   modport slave (
      input  br_valid, func3, rs1, rs2, pc, imm, stall,
      output br_ready, resolve_valid, taken, illegal, redirect_valid, redirect_pc, flush
   );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: one-at-a-time conditional branch resolver.
// IDLE -> EVAL (1 cycle) -> [REDIRECT (held while stall) -> FLUSH (FLUSH_CYCLES)] -> IDLE.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module branch_ctrl #(
   parameter int VAR_WIDTH    = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   branch_ctrl_if.slave bus,
   output logic        busy,
   output logic [31:0] stat_total,
   output logic [31:0] stat_taken
);

   typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} state_t;

   typedef struct packed {
      logic [2:0]           func3;
      logic [VAR_WIDTH-1:0] rs1;
      logic [VAR_WIDTH-1:0] rs2;
      logic [VAR_WIDTH-1:0] pc;
      logic [VAR_WIDTH-1:0] imm;
   } req_t;

   state_t               state, state_nxt;
   req_t                 req, req_nxt;
   logic                 resolve_nxt, taken_nxt, illegal_nxt;
   logic                 redir_v_nxt, flush_nxt;
   logic [VAR_WIDTH-1:0] redir_pc_nxt;
   logic [3:0]           cnt, cnt_nxt;
   logic                 cond, bad_f3;
   logic [VAR_WIDTH-1:0] target;

   assign bus.br_ready = (state == IDLE);
   assign busy         = (state != IDLE);

   // Target wraps modulo 2^VAR_WIDTH; that is legal.
   assign target = req.pc + req.imm;

   // Evaluate the branch condition on the captured operands.
   always_comb begin
      cond   = 1'b0;
      bad_f3 = 1'b0;
      case (req.func3)
         3'b000:  cond = (req.rs1 == req.rs2);
         3'b001:  cond = (req.rs1 != req.rs2);
         3'b100:  cond = ($signed(req.rs1) <  $signed(req.rs2));
         3'b101:  cond = ($signed(req.rs1) >= $signed(req.rs2));
         3'b110:  cond = (req.rs1 <  req.rs2);
         3'b111:  cond = (req.rs1 >= req.rs2);
         default: bad_f3 = 1'b1;
      endcase
   end

   // Next-state and next registered-output logic; pulses default low.
   always_comb begin
      state_nxt    = state;
      req_nxt      = req;
      resolve_nxt  = 1'b0;
      taken_nxt    = 1'b0;
      illegal_nxt  = 1'b0;
      redir_v_nxt  = bus.redirect_valid;
      redir_pc_nxt = bus.redirect_pc;
      flush_nxt    = bus.flush;
      cnt_nxt      = cnt;
      case (state)
         IDLE: begin
            if (bus.br_valid) begin
               req_nxt   = '{bus.func3, bus.rs1, bus.rs2, bus.pc, bus.imm};
               state_nxt = EVAL;
            end
         end
         EVAL: begin
            resolve_nxt = 1'b1;
            state_nxt   = IDLE;
            if (bad_f3 || (cond && target[1:0] != 2'b00)) begin
               illegal_nxt = 1'b1;
            end else if (cond) begin
               taken_nxt    = 1'b1;
               redir_v_nxt  = 1'b1;
               redir_pc_nxt = target;
               state_nxt    = REDIRECT;
            end
         end
         REDIRECT: begin
            if (!bus.stall) begin
               redir_v_nxt = 1'b0;
               if (FLUSH_CYCLES == 0) begin
                  state_nxt = IDLE;
               end else begin
                  flush_nxt = 1'b1;
                  cnt_nxt   = 4'(FLUSH_CYCLES);
                  state_nxt = FLUSH;
               end
            end
         end
         FLUSH: begin
            // Counts down regardless of stall; last flush cycle is cnt==1.
            if (cnt <= 4'd1) begin
               flush_nxt = 1'b0;
               cnt_nxt   = 4'd0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, captured request and registered outputs; reset abandons any branch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state              <= IDLE;
         req                <= '0;
         cnt                <= 4'd0;
         bus.resolve_valid  <= 1'b0;
         bus.taken          <= 1'b0;
         bus.illegal        <= 1'b0;
         bus.redirect_valid <= 1'b0;
         bus.redirect_pc    <= '0;
         bus.flush          <= 1'b0;
      end else begin
         state              <= state_nxt;
         req                <= req_nxt;
         cnt                <= cnt_nxt;
         bus.resolve_valid  <= resolve_nxt;
         bus.taken          <= taken_nxt;
         bus.illegal        <= illegal_nxt;
         bus.redirect_valid <= redir_v_nxt;
         bus.redirect_pc    <= redir_pc_nxt;
         bus.flush          <= flush_nxt;
      end
   end

`ifdef BRANCH_STATS_EN
   // Resolution statistics; both wrap naturally at 2^32.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_total <= 32'd0;
         stat_taken <= 32'd0;
      end else if (bus.resolve_valid) begin
         stat_total <= stat_total + 32'd1;
         if (bus.taken) stat_taken <= stat_taken + 32'd1;
      end
   end
`else
   assign stat_total = 32'd0;
   assign stat_taken = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: handshake timing, conditions, stall hold,
// flush length, illegal cases, PC wrap and mid-flush reset.
module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        busy;
   logic [31:0] stat_total, stat_taken;
   int          n_assert = 0;
   int          n_fail   = 0;

   branch_ctrl_if #(.VAR_WIDTH(32)) bus();

   branch_ctrl #(.VAR_WIDTH(32), .FLUSH_CYCLES(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .busy       (busy),
      .stat_total (stat_total),
      .stat_taken (stat_taken)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request; returns just after the accept edge (state EVAL).
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] i);
      bus.func3    = f3;
      bus.rs1      = a;
      bus.rs2      = b;
      bus.pc       = p;
      bus.imm      = i;
      bus.br_valid = 1'b1;
      tick();
      bus.br_valid = 1'b0;
   endtask

   initial begin
      reset_n      = 1'b0;
      bus.br_valid = 1'b0;
      bus.func3    = 3'd0;
      bus.rs1      = 32'd0;
      bus.rs2      = 32'd0;
      bus.pc       = 32'd0;
      bus.imm      = 32'd0;
      bus.stall    = 1'b0;
      #1;
      chk("rst_br_ready", 32'(bus.br_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_redir_v", 32'(bus.redirect_valid), 32'd0);
      chk("rst_flush", 32'(bus.flush), 32'd0);
      chk("rst_resolve", 32'(bus.resolve_valid), 32'd0);
      chk("rst_stat_total", stat_total, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;

      // BEQ taken: 0x100 + 0x20
      issue(3'b000, 32'h5, 32'h5, 32'h100, 32'h20);
      chk("beq_busy", 32'(busy), 32'd1);
      chk("beq_resolve_early", 32'(bus.resolve_valid), 32'd0);
      tick();
      chk("beq_resolve", 32'(bus.resolve_valid), 32'd1);
      chk("beq_taken", 32'(bus.taken), 32'd1);
      chk("beq_illegal", 32'(bus.illegal), 32'd0);
      chk("beq_redir_v", 32'(bus.redirect_valid), 32'd1);
      chk("beq_redir_pc", bus.redirect_pc, 32'h120);
      tick();
      chk("beq_redir_drop", 32'(bus.redirect_valid), 32'd0);
      chk("beq_flush1", 32'(bus.flush), 32'd1);
      chk("beq_resolve_pulse", 32'(bus.resolve_valid), 32'd0);
      tick();
      chk("beq_flush2", 32'(bus.flush), 32'd1);
      tick();
      chk("beq_flush_end", 32'(bus.flush), 32'd0);
      chk("beq_br_ready", 32'(bus.br_ready), 32'd1);

      // BLT signed: -1 < 1 taken; stall during flush must not extend it
      issue(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8);
      tick();
      chk("blt_taken", 32'(bus.taken), 32'd1);
      chk("blt_redir_pc", bus.redirect_pc, 32'h208);
      tick();
      bus.stall = 1'b1;
      chk("blt_flush1", 32'(bus.flush), 32'd1);
      tick();
      chk("blt_flush2", 32'(bus.flush), 32'd1);
      tick();
      chk("blt_flush_end_stalled", 32'(bus.flush), 32'd0);
      chk("blt_idle", 32'(busy), 32'd0);
      bus.stall = 1'b0;

      // BLTU unsigned: 0xFFFFFFFF < 1 false -> not taken
      issue(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8);
      tick();
      chk("bltu_resolve", 32'(bus.resolve_valid), 32'd1);
      chk("bltu_taken", 32'(bus.taken), 32'd0);
      chk("bltu_redir_v", 32'(bus.redirect_valid), 32'd0);
      tick();
      chk("bltu_idle", 32'(busy), 32'd0);
      chk("bltu_flush", 32'(bus.flush), 32'd0);

      // BNE taken with stall held: redirect stays stable for 3 cycles
      bus.stall = 1'b1;
      issue(3'b001, 32'h1, 32'h2, 32'h300, 32'h40);
      tick();
      chk("bne_resolve", 32'(bus.resolve_valid), 32'd1);
      chk("bne_redir_v0", 32'(bus.redirect_valid), 32'd1);
      chk("bne_redir_pc0", bus.redirect_pc, 32'h340);
      for (int k = 1; k < 3; k++) begin
         tick();
         chk($sformatf("bne_redir_v%0d", k), 32'(bus.redirect_valid), 32'd1);
         chk($sformatf("bne_redir_pc%0d", k), bus.redirect_pc, 32'h340);
         chk($sformatf("bne_noflush%0d", k), 32'(bus.flush), 32'd0);
      end
      bus.stall = 1'b0;
      tick();
      chk("bne_redir_drop", 32'(bus.redirect_valid), 32'd0);
      chk("bne_flush", 32'(bus.flush), 32'd1);
      tick();
      tick();
      chk("bne_idle", 32'(busy), 32'd0);

      // BGE 3>=3 with PC wrap: 0xFFFFFFF0 + 0x20 = 0x10; then reset mid-flush
      issue(3'b101, 32'h3, 32'h3, 32'hFFFF_FFF0, 32'h20);
      tick();
      chk("bge_taken", 32'(bus.taken), 32'd1);
      chk("bge_redir_pc_wrap", bus.redirect_pc, 32'h10);
      tick();
      chk("bge_flush", 32'(bus.flush), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_flush", 32'(bus.flush), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_br_ready", 32'(bus.br_ready), 32'd1);
      #1 reset_n = 1'b1;
      tick();

      // Illegal func3 and misaligned taken target
      issue(3'b010, 32'h1, 32'h1, 32'h100, 32'h20);
      tick();
      chk("f3_illegal", 32'(bus.illegal), 32'd1);
      chk("f3_resolve", 32'(bus.resolve_valid), 32'd1);
      chk("f3_taken", 32'(bus.taken), 32'd0);
      chk("f3_redir_v", 32'(bus.redirect_valid), 32'd0);
      tick();
      chk("f3_illegal_pulse", 32'(bus.illegal), 32'd0);
      issue(3'b000, 32'h7, 32'h7, 32'h100, 32'h2);
      tick();
      chk("mis_illegal", 32'(bus.illegal), 32'd1);
      chk("mis_taken", 32'(bus.taken), 32'd0);
      chk("mis_redir_v", 32'(bus.redirect_valid), 32'd0);
      tick();
      chk("mis_idle", 32'(busy), 32'd0);
`ifdef BRANCH_STATS_EN
      chk("stat_total_ill", stat_total, 32'd2);
`else
      chk("stat_total_ill", stat_total, 32'd0);
`endif
      chk("stat_taken_ill", stat_taken, 32'd0);

      // Normal branch after reset: BGEU 0xFFFFFFFF >= 1, 0x400 - 4
      issue(3'b111, 32'hFFFF_FFFF, 32'h1, 32'h400, 32'hFFFF_FFFC);
      tick();
      chk("bgeu_resolve", 32'(bus.resolve_valid), 32'd1);
      chk("bgeu_taken", 32'(bus.taken), 32'd1);
      chk("bgeu_redir_pc", bus.redirect_pc, 32'h3FC);
      tick();
      tick();
      tick();
      chk("bgeu_idle", 32'(bus.br_ready), 32'd1);
`ifdef BRANCH_STATS_EN
      chk("stat_total_end", stat_total, 32'd3);
      chk("stat_taken_end", stat_taken, 32'd1);
`else
      chk("stat_total_end", stat_total, 32'd0);
      chk("stat_taken_end", stat_taken, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
